// File: rtl/pipe_word_assembler.sv
// Packs the 16-bit pipe-in stream into 48-bit entries and buffers them in a FIFO.
// ep_ready throttles the host so that a whole block is never accepted without room to store it.
module pipe_word_assembler #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int BLOCK_WORDS = 48
) (
  input  logic          ti_clk,
  input  logic          reset,
  input  logic          ep_write,
  input  logic          ep_blockstrobe,
  input  logic [15:0]   ep_dataout,
  output logic          ep_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [47:0]   out_data,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          misalign
);

  localparam int          FW   = AW + 4;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]    phase_q, phase_d;
  logic [15:0]   w0_q, w0_d, w1_q, w1_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          misalign_q, misalign_d;
  logic          init_q, init_d;

  logic [47:0]   mem [DEPTH];
  logic          pop, push_try, push;
  logic [47:0]   entry;
  logic [FW-1:0] room_words, need_words;

  always_comb begin
    pop        = (level_q != '0) && out_ready;
    push_try   = ep_write && (phase_q == 2'd2);
    push       = push_try && ((level_q != FULL) || pop);
    entry      = {ep_dataout, w1_q, w0_q};

    phase_d    = phase_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    misalign_d = misalign_q;
    init_d     = 1'b0;

    if (ep_write) begin
      case (phase_q)
        2'd0: begin
          w0_d    = ep_dataout;
          phase_d = 2'd1;
        end
        2'd1: begin
          w1_d    = ep_dataout;
          phase_d = 2'd2;
        end
        default: phase_d = 2'd0;
      endcase
    end else if (ep_blockstrobe && (phase_q != 2'd0)) begin
      phase_d    = 2'd0;
      misalign_d = 1'b1;
    end

    // A third word with no slot available loses the whole entry.
    if (push_try && !push) overflow_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      phase_q    <= 2'd0;
      w0_q       <= '0;
      w1_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      phase_q    <= phase_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
      init_q     <= init_d;
    end
  end

  always_ff @(posedge ti_clk) begin
    if (push) mem[wr_ptr_q] <= entry;
  end

  // free = 3*(DEPTH-level) - phase may go negative, so compare without subtracting.
  always_comb begin
    room_words = FW'(FULL - level_q) * FW'(3);
    need_words = FW'(BLOCK_WORDS) + FW'(phase_q);
  end

  assign ep_ready  = !init_q && (room_words >= need_words);
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : 48'h0;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_pipe_word_assembler.sv
// Directed bench for pipe_word_assembler with a queue scoreboard of expected entries.
module tb_pipe_word_assembler;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int BW    = 48;

  logic          ti_clk = 1'b0;
  logic          reset = 1'b0;
  logic          ep_write = 1'b0;
  logic          ep_blockstrobe = 1'b0;
  logic [15:0]   ep_dataout = 16'h0;
  logic          ep_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [47:0]   out_data;
  logic [AW:0]   level;
  logic          overflow;
  logic          misalign;

  pipe_word_assembler #(.DEPTH(DEPTH), .AW(AW), .BLOCK_WORDS(BW)) dut (
    .ti_clk(ti_clk), .reset(reset), .ep_write(ep_write), .ep_blockstrobe(ep_blockstrobe),
    .ep_dataout(ep_dataout), .ep_ready(ep_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow(overflow), .misalign(misalign)
  );

  always #5 ti_clk = ~ti_clk;

  int          checks = 0;
  int          errors = 0;
  logic [47:0] sb[$];
  int          mphase = 0;
  logic [15:0] mw0 = 16'h0, mw1 = 16'h0;
  logic        movf = 1'b0, mmis = 1'b0, minit = 1'b1;
  int          npops = 0;
  int          maxlvl = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the model, advance, then compare registered outputs.
  task automatic cycle(input logic wr, input logic [15:0] d, input logic bs,
                       input logic rdy, input logic rst);
    int exp_rdy;
    ep_write = wr; ep_dataout = d; ep_blockstrobe = bs; out_ready = rdy; reset = rst;
    if (rst) begin
      sb.delete(); mphase = 0; movf = 1'b0; mmis = 1'b0; minit = 1'b1;
    end else begin
      if (sb.size() != 0 && rdy) begin
        chk("pop_data", out_data, sb[0]);
        void'(sb.pop_front());
        npops++;
      end
      if (wr) begin
        if (mphase == 0) begin mw0 = d; mphase = 1; end
        else if (mphase == 1) begin mw1 = d; mphase = 2; end
        else begin
          mphase = 0;
          if (sb.size() == DEPTH) movf = 1'b1;
          else sb.push_back({d, mw1, mw0});
        end
      end else if (bs && mphase != 0) begin
        mphase = 0; mmis = 1'b1;
      end
      minit = 1'b0;
    end
    @(posedge ti_clk);
    #1;
    ep_write = 1'b0; ep_blockstrobe = 1'b0; reset = 1'b0;
    if (sb.size() > maxlvl) maxlvl = sb.size();
    exp_rdy = (!minit && (3 * (DEPTH - sb.size()) - mphase >= BW)) ? 1 : 0;
    chk("level", 48'(level), 48'(sb.size()));
    chk("out_valid", 48'(out_valid), 48'(sb.size() != 0));
    chk("ep_ready", 48'(ep_ready), 48'(exp_rdy));
    chk("overflow", 48'(overflow), 48'(movf));
    chk("misalign", 48'(misalign), 48'(mmis));
    if (sb.size() == 0) chk("empty_data", out_data, 48'h0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 16'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic wr_word(input logic [15:0] d, input logic rdy);
    cycle(1'b1, d, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) idle(1'b1);
    chk("drain_empty", 48'(out_valid), 48'h0);
  endtask

  initial begin
    int wcnt;
    // Reset state
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_ep_ready", 48'(ep_ready), 48'h0);
    chk("rst_level", 48'(level), 48'h0);
    idle(1'b0);
    chk("rst_ready_rise", 48'(ep_ready), 48'h1);

    // Basic packing
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    wr_word(16'h1111, 1'b0);
    wr_word(16'h2222, 1'b0);
    wr_word(16'h3333, 1'b0);
    chk("basic_data", out_data, 48'h3333_2222_1111);
    chk("basic_level", 48'(level), 48'h1);
    chk("basic_ready", 48'(ep_ready), 48'h1);
    drain();

    // Misalignment
    wr_word(16'h0001, 1'b0);
    wr_word(16'h0002, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("mis_flag", 48'(misalign), 48'h1);
    wr_word(16'hAAAA, 1'b0);
    wr_word(16'hBBBB, 1'b0);
    wr_word(16'hCCCC, 1'b0);
    chk("mis_level", 48'(level), 48'h1);
    chk("mis_data", out_data, 48'hCCCC_BBBB_AAAA);
    drain();

    // Throttle threshold, then overflow at full
    do_reset();
    wcnt = 0;
    for (int e = 0; e < 48; e++)
      for (int k = 0; k < 3; k++) begin wr_word(16'(wcnt), 1'b0); wcnt++; end
    chk("thr_level48", 48'(level), 48'd48);
    chk("thr_ready48", 48'(ep_ready), 48'h1);
    for (int k = 0; k < 3; k++) begin wr_word(16'(wcnt), 1'b0); wcnt++; end
    chk("thr_ready49", 48'(ep_ready), 48'h0);
    for (int e = 49; e < DEPTH; e++)
      for (int k = 0; k < 3; k++) begin wr_word(16'(wcnt), 1'b0); wcnt++; end
    chk("full_level", 48'(level), 48'd64);
    chk("full_noovf", 48'(overflow), 48'h0);
    wr_word(16'hDEAD, 1'b0);
    wr_word(16'hBEEF, 1'b0);
    wr_word(16'hF00D, 1'b0);
    chk("ovf_flag", 48'(overflow), 48'h1);
    chk("ovf_level", 48'(level), 48'd64);
    wr_word(16'h5A5A, 1'b0);
    wr_word(16'hA5A5, 1'b0);
    wr_word(16'h3C3C, 1'b1);
    chk("ovf_pushpop_level", 48'(level), 48'd64);
    drain();

    // Wrap-around with continuous traffic
    do_reset();
    wcnt = 0;
    npops = 0;
    maxlvl = 0;
    for (int b = 0; b < 63; b++) begin
      for (int t = 0; t < 300 && !ep_ready; t++) idle(1'($urandom_range(0, 1)));
      chk("blk_ready", 48'(ep_ready), 48'h1);
      cycle(1'b0, 16'h0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < BW; k++) begin
        wr_word(16'(wcnt), 1'($urandom_range(0, 1)));
        wcnt++;
      end
    end
    drain();
    chk("stream_count", 48'(npops), 48'd1008);
    chk("stream_maxlvl", 48'(maxlvl <= DEPTH), 48'h1);
    chk("stream_noovf", 48'(overflow), 48'h0);

    // Reset mid-operation
    for (int k = 0; k < 30; k++) wr_word(16'(k + 16'h100), 1'b0);
    wr_word(16'h0777, 1'b0);
    chk("pre_rst_level", 48'(level), 48'd10);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("midrst_level", 48'(level), 48'h0);
    chk("midrst_valid", 48'(out_valid), 48'h0);
    chk("midrst_ready", 48'(ep_ready), 48'h0);
    idle(1'b0);
    chk("midrst_ready_rise", 48'(ep_ready), 48'h1);
    wr_word(16'h1234, 1'b0);
    wr_word(16'h5678, 1'b0);
    wr_word(16'h9ABC, 1'b0);
    chk("postrst_data", out_data, 48'h9ABC_5678_1234);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
